// File: rtl/gte_bist_pkg.sv
// Shared definitions for the comparator self-test controller.
// Holds the FSM state encoding and the default sweep parameters.
package gte_bist_pkg;

  localparam int unsigned DEF_WIDTH  = 6;
  localparam int unsigned DEF_SETTLE = 1;
  localparam int unsigned DEF_ERR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gte_ref.sv
// Golden combinational reference: unsigned a >= b.
// Kept standalone so other comparator checkers can reuse it.
module gte_ref #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_gte_c
);

  assign o_gte_c = (i_a >= i_b);

endmodule

// File: rtl/gte_bist.sv
// Exhaustive sweep self-test for a WIDTH-bit GTE comparator: drives {a,b},
// checks dut_gte against gte_ref, counts mismatches and captures the first one.
module gte_bist
  import gte_bist_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned SETTLE = DEF_SETTLE,
  parameter int unsigned ERR_W  = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             dut_gte,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_vld
);

  localparam int unsigned VEC_W = 2 * WIDTH;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_fail_a;
  logic [WIDTH-1:0]   r_fail_b;
  logic [SET_W-1:0]   r_settle;
  logic [ERR_W-1:0]   r_err_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_fail_vld;

  logic               w_ref_gte;
  logic               w_mismatch;
  logic               w_last_vec;
  logic [VEC_W-1:0]   w_vec_nxt;

  gte_ref #(.WIDTH(WIDTH)) u_ref (
    .i_a     (r_a),
    .i_b     (r_b),
    .o_gte_c (w_ref_gte)
  );

  assign w_mismatch = (dut_gte != w_ref_gte);
  assign w_last_vec = &{r_a, r_b};
  assign w_vec_nxt  = {r_a, r_b} + VEC_W'(1);

  // Sweep FSM; the {a,b} wrap point is the sole terminator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_fail_a   <= '0;
      r_fail_b   <= '0;
      r_settle   <= '0;
      r_err_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state    <= ST_SETTLE;
            r_a        <= '0;
            r_b        <= '0;
            r_settle   <= '0;
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_a   <= '0;
            r_fail_b   <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (r_settle == SET_LAST) begin
            r_settle <= '0;
            r_state  <= ST_CHECK;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            if (r_err_cnt != '1) begin
              r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
            if (!r_fail_vld) begin
              r_fail_vld <= 1'b1;
              r_fail_a   <= r_a;
              r_fail_b   <= r_b;
            end
          end
          if (w_last_vec) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            {r_a, r_b} <= w_vec_nxt;
            r_state    <= ST_SETTLE;
          end
        end
      endcase
    end
  end

  assign a        = r_a;
  assign b        = r_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err_cnt  = r_err_cnt;
  assign fail_a   = r_fail_a;
  assign fail_b   = r_fail_b;
  assign fail_vld = r_fail_vld;
  assign pass     = r_done && (r_err_cnt == '0);

endmodule

// File: tb/tb_gte_bist.sv
// Scoreboard bench for gte_bist (WIDTH=2, SETTLE=1) with a 16-bit and a
// saturating 3-bit error counter instance fed by the same modelled comparator.
module tb_gte_bist;

  localparam int unsigned W  = 2;
  localparam int unsigned S  = 1;
  localparam int unsigned NV = 16;

  logic clk;
  logic reset_n;
  logic start;
  int   mode;
  logic [15:0] mask;
  int   cyc = 0;
  int   n_done = 0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] a0, b0, fa0, fb0, a1, b1, fa1, fb1;
  logic         busy0, done0, pass0, fv0, gte0;
  logic         busy1, done1, pass1, fv1, gte1;
  logic [15:0]  err0;
  logic [2:0]   err1;

  typedef struct {
    int err16;
    int err3;
    int fvld;
    int fa;
    int fb;
    int done_cyc;
  } exp_t;

  exp_t exp_q[$];

  // Comparator under test: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted, 4 random faults
  function automatic logic cmp(input int m, input logic [15:0] msk,
                               input logic [W-1:0] x, input logic [W-1:0] y);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return !(x >= y);
      4:       return (x >= y) ^ msk[{x, y}];
      default: return (x >= y);
    endcase
  endfunction

  assign gte0 = cmp(mode, mask, a0, b0);
  assign gte1 = cmp(mode, mask, a1, b1);

  gte_bist #(.WIDTH(W), .SETTLE(S), .ERR_W(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a0), .b(b0),
    .dut_gte(gte0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_a(fa0), .fail_b(fb0), .fail_vld(fv0)
  );

  gte_bist #(.WIDTH(W), .SETTLE(S), .ERR_W(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a1), .b(b1),
    .dut_gte(gte1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_a(fa1), .fail_b(fb1), .fail_vld(fv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Reference: walk every (a,b) pair in sweep order and tally mismatches
  function automatic exp_t model(input int m, input logic [15:0] msk, input int start_cyc);
    exp_t e;
    int   n;
    n = 0;
    e.fvld = 0;
    e.fa = 0;
    e.fb = 0;
    for (int av = 0; av < 4; av++) begin
      for (int bv = 0; bv < 4; bv++) begin
        int truth;
        int got;
        truth = (av >= bv) ? 1 : 0;
        case (m)
          1:       got = 0;
          2:       got = 1;
          3:       got = 1 - truth;
          4:       got = truth ^ int'(msk[av * 4 + bv]);
          default: got = truth;
        endcase
        if (got != truth) begin
          n++;
          if (e.fvld == 0) begin
            e.fvld = 1;
            e.fa = av;
            e.fb = bv;
          end
        end
      end
    end
    e.err16 = (n > 65535) ? 65535 : n;
    e.err3  = (n > 7) ? 7 : n;
    e.done_cyc = start_cyc + int'(NV * (S + 1));
    return e;
  endfunction

  // Monitor: pop one expectation on each rising edge of done
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done0 && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("err_cnt16", int'(err0), e.err16);
          chk("err_cnt3", int'(err1), e.err3);
          chk("pass16", int'(pass0), (e.err16 == 0) ? 1 : 0);
          chk("pass3", int'(pass1), (e.err3 == 0) ? 1 : 0);
          chk("fail_vld", int'(fv0), e.fvld);
          chk("fail_a", int'(fa0), e.fa);
          chk("fail_b", int'(fb0), e.fb);
          chk("fail_a3", int'(fa1), e.fa);
          chk("fail_b3", int'(fb1), e.fb);
          chk("final_a", int'(a0), 3);
          chk("final_b", int'(b0), 3);
          chk("busy_at_done", int'(busy0), 0);
          chk("done3", int'(done1), 1);
        end
        n_done++;
      end
      prev_done = done0;
    end
  end

  task automatic wait_done();
    int tgt;
    int k;
    tgt = n_done + 1;
    k = 0;
    while (n_done < tgt && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (n_done < tgt) chk("done_timeout", n_done, tgt);
  endtask

  task automatic kick(input int m, input logic [15:0] msk);
    mode = m;
    mask = msk;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_start", int'(busy0), 1);
    chk("done_cleared", int'(done0), 0);
    chk("err_cleared", int'(err0), 0);
    chk("fvld_cleared", int'(fv0), 0);
    exp_q.push_back(model(m, msk, cyc));
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    mode = 0;
    mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_fvld", int'(fv0), 0);
    chk("rst_ab", int'({a0, b0, fa0, fb0}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Good, stuck-0, stuck-1, inverted (saturates the 3-bit counter)
    for (int m = 0; m < 4; m++) begin
      kick(m, 16'h0);
      wait_done();
    end
    for (int i = 0; i < 4; i++) begin
      kick(4, 16'($urandom));
      wait_done();
    end

    // Asynchronous reset in the middle of a stuck-0 sweep
    kick(1, 16'h0);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_err", int'(err0), 0);
    chk("midrst_err3", int'(err1), 0);
    chk("midrst_ab", int'({a0, b0}), 0);
    chk("midrst_fvld", int'(fv0), 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy0), 0);
    chk("idle_done", int'(done0), 0);
    chk("idle_ab", int'({a0, b0}), 0);
    kick(0, 16'h0);
    wait_done();

    // start held high: ignored while busy, restarts from DONE
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("held_busy", int'(busy0), 1);
    exp_q.push_back(model(1, 16'h0, cyc));
    wait_done();
    #1;
    chk("restart_done", int'(done0), 0);
    chk("restart_err", int'(err0), 0);
    chk("restart_busy", int'(busy0), 1);
    chk("restart_fvld", int'(fv0), 0);
    exp_q.push_back(model(1, 16'h0, cyc));
    @(negedge clk);
    start = 1'b0;
    wait_done();

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
